// File: rtl/sha_sched_pkg.sv
// Shared types and constants for the SHA-2 message-schedule buffer.
package sha_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    DRAIN
  } sched_state_e;

  typedef enum logic {
    SEL0,
    SEL1
  } sigma_sel_e;

  localparam int MEM_DEPTH = 16;

  // SHA-256 small-sigma rotate/shift amounts
  localparam int S256_S0_R1 = 7;
  localparam int S256_S0_R2 = 18;
  localparam int S256_S0_SH = 3;
  localparam int S256_S1_R1 = 17;
  localparam int S256_S1_R2 = 19;
  localparam int S256_S1_SH = 10;

  // SHA-512 small-sigma rotate/shift amounts
  localparam int S512_S0_R1 = 1;
  localparam int S512_S0_R2 = 8;
  localparam int S512_S0_SH = 7;
  localparam int S512_S1_R1 = 19;
  localparam int S512_S1_R2 = 61;
  localparam int S512_S1_SH = 6;

  // Only the two real SHA-2 schedule shapes are meaningful, and the
  // buffer depth is tied to the W[t-16] recurrence.
  function automatic bit sched_params_legal(input int word_w, input int rounds, input int mem_w);
    return (mem_w == MEM_DEPTH) &&
           (((word_w == 32) && (rounds == 64)) || ((word_w == 64) && (rounds == 80)));
  endfunction

endpackage

// File: rtl/msg_sigma.sv
// Combinational SHA-2 small sigma (sigma0 or sigma1) for 32- or 64-bit words.
module msg_sigma
  import sha_sched_pkg::*;
#(
  parameter int         WORD_W = 32,
  parameter sigma_sel_e SEL    = SEL0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  localparam bit WIDE = (WORD_W == 64);
  localparam int R1 = (SEL == SEL0) ? (WIDE ? S512_S0_R1 : S256_S0_R1)
                                    : (WIDE ? S512_S1_R1 : S256_S1_R1);
  localparam int R2 = (SEL == SEL0) ? (WIDE ? S512_S0_R2 : S256_S0_R2)
                                    : (WIDE ? S512_S1_R2 : S256_S1_R2);
  localparam int SH = (SEL == SEL0) ? (WIDE ? S512_S0_SH : S256_S0_SH)
                                    : (WIDE ? S512_S1_SH : S256_S1_SH);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int r);
    return (v >> r) | (v << (WORD_W - r));
  endfunction

  // Two rotations and a logical shift, folded together with XOR
  always_comb begin
    y = rotr(x, R1) ^ rotr(x, R2) ^ (x >> SH);
  end

endmodule

// File: rtl/msg_schedule_buf.sv
// Registered SHA-2 message schedule: loads W[0..15] into a 16-entry circular
// buffer, expands the remaining rounds in place and streams W[t] out in order.
module msg_schedule_buf
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int MEM_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_word,
  output logic [$clog2(ROUNDS)-1:0] out_round,
  output logic                      busy,
  output logic                      done
);

  localparam int RW = $clog2(ROUNDS);

  if (!sched_params_legal(WORD_W, ROUNDS, MEM_W)) begin : g_param_check
    $error("msg_schedule_buf: illegal WORD_W/ROUNDS/MEM_W combination");
  end

  sched_state_e      state_q, state_d;
  logic [RW-1:0]     t_q;
  logic [WORD_W-1:0] mem [MEM_DEPTH];

  logic              adv;
  logic              load_fire;
  logic              gen_fire;
  logic [3:0]        t_lo, idx2, idx7, idx15, idx16;
  logic [WORD_W-1:0] sig0, sig1, expanded, new_word;

  // The output register can take a new word when it is empty or being drained
  assign adv       = !out_valid || out_ready;
  assign load_fire = (state_q == LOAD) && in_valid && adv;
  assign gen_fire  = (state_q == EXPAND) && adv;

  // Circular-buffer taps for W[t-2], W[t-7], W[t-15] and W[t-16]
  assign t_lo  = t_q[3:0];
  assign idx2  = t_lo + 4'd14;
  assign idx7  = t_lo + 4'd9;
  assign idx15 = t_lo + 4'd1;
  assign idx16 = t_lo;

  msg_sigma #(.WORD_W(WORD_W), .SEL(SEL0)) u_sigma0 (
    .x (mem[idx15]),
    .y (sig0)
  );

  msg_sigma #(.WORD_W(WORD_W), .SEL(SEL1)) u_sigma1 (
    .x (mem[idx2]),
    .y (sig1)
  );

  assign expanded = sig1 + mem[idx7] + sig0 + mem[idx16];
  assign new_word = (state_q == LOAD) ? in_word : expanded;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the state-derived handshake and status outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        in_ready = adv;
        if (load_fire && (t_q == RW'(15))) state_d = EXPAND;
      end
      EXPAND: begin
        if (gen_fire && (t_q == RW'(ROUNDS - 1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Round counter, buffer writes (new word replaces the W[t-16] slot it just read) and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q       <= '0;
      out_word  <= '0;
      out_round <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      done <= (state_q == DRAIN) && out_valid && out_ready;
      if ((state_q == IDLE) && start) begin
        t_q <= '0;
      end
      if (load_fire || gen_fire) begin
        mem[idx16] <= new_word;
        out_word   <= new_word;
        out_round  <= t_q;
        out_valid  <= 1'b1;
        t_q        <= t_q + RW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msg_schedule_buf.sv
// Scoreboard bench for msg_schedule_buf: a SHA-256 instance and a SHA-512 instance.
module tb_msg_schedule_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // SHA-256 instance signals
  logic        a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_done;
  logic [31:0] a_in_word, a_out_word;
  logic [5:0]  a_out_round;

  // SHA-512 instance signals
  logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
  logic [63:0] b_in_word, b_out_word;
  logic [6:0]  b_out_round;

  typedef struct {
    logic [63:0] word;
    int          round;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] blk32[16];
  logic [63:0] blk64[16];
  logic [31:0] cap32[64];
  bit          hold_start   = 1'b0;

  msg_schedule_buf #(.WORD_W(32), .ROUNDS(64), .MEM_W(16)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .start     (a_start),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_word   (a_in_word),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_word  (a_out_word),
    .out_round (a_out_round),
    .busy      (a_busy),
    .done      (a_done)
  );

  msg_schedule_buf #(.WORD_W(64), .ROUNDS(80), .MEM_W(16)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .start     (b_start),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_word   (b_in_word),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_word  (b_out_word),
    .out_round (b_out_round),
    .busy      (b_busy),
    .done      (b_done)
  );

  // Reference small-sigma functions written as explicit bit concatenations
  function automatic logic [31:0] m_s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] m_s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [63:0] m_s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
  endfunction

  function automatic logic [63:0] m_s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
  endfunction

  task automatic do_reset;
    a_start = 1'b0; a_in_valid = 1'b0; a_in_word = '0; a_out_ready = 1'b0;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_word = '0; b_out_ready = 1'b0;
    hold_start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic set_abc_block;
    for (int i = 0; i < 16; i++) blk32[i] = 32'h0;
    blk32[0]  = 32'h61626380;
    blk32[15] = 32'h00000018;
  endtask

  // Streams one SHA-256 block through dut32 against the scoreboard
  task automatic run_block32(input int gap_every, input bit rand_ready, input int abort_round,
                             output int n_out, output int n_done, output int lag, output bit aborted);
    logic [31:0] w[64];
    logic [31:0] prev_word;
    logic [5:0]  prev_round;
    exp_t        e;
    int          in_idx, cyc, post, last_cons, done_cyc;
    bit          prev_stall;
    for (int i = 0; i < 16; i++) w[i] = blk32[i];
    for (int i = 16; i < 64; i++) w[i] = m_s1_32(w[i-2]) + w[i-7] + m_s0_32(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) cap32[i] = 32'h0;
    exp_q.delete();
    in_idx = 0; cyc = 0; post = 0; last_cons = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_word = '0; prev_round = '0;
    n_out = 0; n_done = 0; lag = -1; aborted = 1'b0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); if (!hold_start) a_start = 1'b0;
    while (post < 4 && cyc < 3000) begin
      a_in_valid = (in_idx < 16) && !(gap_every > 0 && (cyc % gap_every) == gap_every - 1);
      if (a_in_valid) a_in_word = blk32[in_idx];
      else            a_in_word = $urandom();
      a_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (abort_round >= 0 && a_out_valid && a_out_round == 6'(abort_round)) begin
        aborted = 1'b1;
        break;
      end
      if (in_idx >= 16 && post == 0) begin
        tests_run++;
        if (a_in_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL in_ready_outside_load: got %b want 0 (cycle %0d)", a_in_ready, cyc);
        end
      end
      if (prev_stall) begin
        tests_run++;
        if (a_out_valid !== 1'b1 || a_out_word !== prev_word || a_out_round !== prev_round) begin
          tests_failed++;
          $display("[TB] FAIL stall_hold: got v=%b w=%h r=%0d want v=1 w=%h r=%0d",
                   a_out_valid, a_out_word, a_out_round, prev_word, prev_round);
        end
      end
      if (a_done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      if (a_in_valid && a_in_ready) begin
        e.word = 64'(blk32[in_idx]); e.round = in_idx; exp_q.push_back(e);
        if (in_idx == 15) begin
          for (int i = 16; i < 64; i++) begin
            e.word = 64'(w[i]); e.round = i; exp_q.push_back(e);
          end
        end
        in_idx++;
      end
      if (a_out_valid && a_out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL extra_word: got w=%h r=%0d want no output", a_out_word, a_out_round);
        end else begin
          e = exp_q.pop_front();
          if (a_out_word !== e.word[31:0] || a_out_round !== 6'(e.round)) begin
            tests_failed++;
            $display("[TB] FAIL word32: got w=%h r=%0d want w=%h r=%0d",
                     a_out_word, a_out_round, e.word[31:0], e.round);
          end
        end
        cap32[a_out_round] = a_out_word;
        n_out++;
        last_cons = cyc;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_word  = a_out_word;
      prev_round = a_out_round;
      if (n_out >= 64) post++;
      cyc++;
      @(negedge clk);
    end
    if (!aborted && post < 4) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL timeout32: got %0d words want 64", n_out);
    end
    a_in_valid = 1'b0;
    if (n_done > 0) lag = done_cyc - last_cons;
  endtask

  // Streams one SHA-512 block through dut64 against the scoreboard
  task automatic run_block64(output int n_out, output int n_done, output int max_round);
    logic [63:0] w[80];
    exp_t        e;
    int          in_idx, cyc, post;
    for (int i = 0; i < 16; i++) w[i] = blk64[i];
    for (int i = 16; i < 80; i++) w[i] = m_s1_64(w[i-2]) + w[i-7] + m_s0_64(w[i-15]) + w[i-16];
    exp_q.delete();
    in_idx = 0; cyc = 0; post = 0;
    n_out = 0; n_done = 0; max_round = -1;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    while (post < 4 && cyc < 3000) begin
      b_in_valid = (in_idx < 16);
      if (b_in_valid) b_in_word = blk64[in_idx];
      else            b_in_word = '0;
      b_out_ready = 1'b1;
      #1;
      if (b_done === 1'b1) n_done++;
      if (b_in_valid && b_in_ready) begin
        e.word = blk64[in_idx]; e.round = in_idx; exp_q.push_back(e);
        if (in_idx == 15) begin
          for (int i = 16; i < 80; i++) begin
            e.word = w[i]; e.round = i; exp_q.push_back(e);
          end
        end
        in_idx++;
      end
      if (b_out_valid && b_out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL extra_word64: got w=%h r=%0d want no output", b_out_word, b_out_round);
        end else begin
          e = exp_q.pop_front();
          if (b_out_word !== e.word || b_out_round !== 7'(e.round)) begin
            tests_failed++;
            $display("[TB] FAIL word64: got w=%h r=%0d want w=%h r=%0d",
                     b_out_word, b_out_round, e.word, e.round);
          end
        end
        if (int'(b_out_round) > max_round) max_round = int'(b_out_round);
        n_out++;
      end
      if (n_out >= 80) post++;
      cyc++;
      @(negedge clk);
    end
    if (post < 4) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL timeout64: got %0d words want 80", n_out);
    end
    b_in_valid = 1'b0;
  endtask

  task automatic check_block_end(input string name, input int n_out, input int want_out, input int n_done);
    tests_run++;
    if (n_out != want_out) begin
      tests_failed++;
      $display("[TB] FAIL %s_count: got %0d words want %0d", name, n_out, want_out);
    end
    tests_run++;
    if (n_done != 1) begin
      tests_failed++;
      $display("[TB] FAIL %s_done: got %0d done pulses want 1", name, n_done);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_leftover: got %0d unconsumed want 0", name, exp_q.size());
    end
  endtask

  task automatic check_abc_words(input string name);
    logic [31:0] want[4];
    want[0] = 32'h61626380; want[1] = 32'h000F0000; want[2] = 32'h7DA86405; want[3] = 32'h600003C6;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap32[16+i] !== want[i]) begin
        tests_failed++;
        $display("[TB] FAIL %s_w%0d: got %h want %h", name, 16 + i, cap32[16+i], want[i]);
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    #1;
    tests_run++;
    if ({a_out_valid, a_busy, a_done, a_in_ready} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl32: got v/busy/done/rdy=%b want 0000", {a_out_valid, a_busy, a_done, a_in_ready});
    end
    tests_run++;
    if (a_out_word !== 32'h0 || a_out_round !== 6'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data32: got w=%h r=%0d want 0/0", a_out_word, a_out_round);
    end
    tests_run++;
    if ({b_out_valid, b_busy, b_done, b_in_ready} !== 4'b0 || b_out_word !== 64'h0 || b_out_round !== 7'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset64: got v/busy/done/rdy=%b w=%h r=%0d want all 0",
               {b_out_valid, b_busy, b_done, b_in_ready}, b_out_word, b_out_round);
    end
  endtask

  task automatic test_boundaries;
    do_reset();
    @(negedge clk); a_in_valid = 1'b1; a_in_word = 32'hA5A5A5A5; a_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_in_valid: got rdy=%b v=%b busy=%b want 0/0/0", a_in_ready, a_out_valid, a_busy);
    end
    @(negedge clk); rst = 1'b1; a_start = 1'b1;
    @(negedge clk); rst = 1'b0; a_start = 1'b0; a_in_valid = 1'b0;
    #1;
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL start_with_rst: got busy=%b want 0", a_busy);
    end
  endtask

  task automatic test_abc;
    int n_out, n_done, lag;
    bit aborted;
    do_reset();
    set_abc_block();
    run_block32(0, 1'b0, -1, n_out, n_done, lag, aborted);
    check_block_end("abc", n_out, 64, n_done);
    check_abc_words("abc");
    tests_run++;
    if (lag != 1) begin
      tests_failed++;
      $display("[TB] FAIL abc_done_lag: got %0d cycles want 1", lag);
    end
  endtask

  task automatic test_stall;
    int n_out, n_done, lag;
    bit aborted;
    do_reset();
    set_abc_block();
    run_block32(0, 1'b1, -1, n_out, n_done, lag, aborted);
    check_block_end("stall", n_out, 64, n_done);
    check_abc_words("stall");
  endtask

  task automatic test_gaps;
    int n_out, n_done, lag;
    bit aborted;
    do_reset();
    for (int i = 0; i < 16; i++) blk32[i] = $urandom();
    run_block32(3, 1'b0, -1, n_out, n_done, lag, aborted);
    check_block_end("gaps", n_out, 64, n_done);
  endtask

  task automatic test_reset_mid;
    int n_out, n_done, lag, late_done;
    bit aborted;
    do_reset();
    set_abc_block();
    run_block32(0, 1'b0, 30, n_out, n_done, lag, aborted);
    tests_run++;
    if (!aborted) begin
      tests_failed++;
      $display("[TB] FAIL abort_reach: got round 30 seen=%b want 1", aborted);
    end
    rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if ({a_out_valid, a_busy, a_done, a_in_ready} !== 4'b0 || a_out_word !== 32'h0 || a_out_round !== 6'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got v/busy/done/rdy=%b w=%h r=%0d want all 0",
               {a_out_valid, a_busy, a_done, a_in_ready}, a_out_word, a_out_round);
    end
    rst = 1'b0;
    late_done = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (a_done === 1'b1) late_done++;
    end
    tests_run++;
    if (late_done != 0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_done: got %0d done pulses want 0", late_done);
    end
    run_block32(0, 1'b0, -1, n_out, n_done, lag, aborted);
    check_block_end("rerun", n_out, 64, n_done);
    check_abc_words("rerun");
  endtask

  task automatic test_back_to_back;
    int n_out, n_done, lag;
    bit aborted;
    do_reset();
    hold_start = 1'b1;
    set_abc_block();
    run_block32(0, 1'b0, -1, n_out, n_done, lag, aborted);
    check_block_end("b2b_first", n_out, 64, n_done);
    #1;
    tests_run++;
    if (a_busy !== 1'b1 || a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_restart: got busy=%b v=%b want 1/0", a_busy, a_out_valid);
    end
    for (int i = 0; i < 16; i++) blk32[i] = $urandom();
    run_block32(0, 1'b1, -1, n_out, n_done, lag, aborted);
    check_block_end("b2b_second", n_out, 64, n_done);
    hold_start = 1'b0;
    a_start = 1'b0;
  endtask

  task automatic test_sha512;
    int n_out, n_done, max_round;
    do_reset();
    for (int i = 0; i < 16; i++) blk64[i] = 64'h0;
    run_block64(n_out, n_done, max_round);
    check_block_end("zero64", n_out, 80, n_done);
    tests_run++;
    if (max_round != 79) begin
      tests_failed++;
      $display("[TB] FAIL zero64_last_round: got %0d want 79", max_round);
    end
    for (int i = 0; i < 16; i++) blk64[i] = {$urandom(), $urandom()};
    run_block64(n_out, n_done, max_round);
    check_block_end("rand64", n_out, 80, n_done);
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_abc();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_sha512();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case a handshake never completes
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit reached want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/msg_schedule_buf.md
Name: msg_schedule_buf

Overview:
Parametrised, registered SHA-2 message-schedule unit that replaces the combinational 16-word W store.
- Accepts the 16 block words over a valid/ready stream.
- Stores them in a 16-entry circular buffer.
- Expands the remaining rounds internally using W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
- Emits one W word per round, in order, to the compression core over a valid/ready stream.
- Supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds).

Parameters:
WORD_W, 32, word width; legal values are 32 (SHA-256) and 64 (SHA-512).
ROUNDS, 64, total W words per block; must be 64 when WORD_W=32 and 80 when WORD_W=64.
MEM_W, 16, circular buffer depth; fixed at 16, and any other value is an elaboration error.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a new block; honoured only in IDLE.
in_valid  in  1  in_word is valid.
in_ready  out  1  unit accepts in_word this cycle.
in_word  in  WORD_W  block word W[0..15], in order.
out_valid  out  1  out_word/out_round are valid.
out_ready  in  1  consumer accepts output.
out_word  out  WORD_W  W[t].
out_round  out  $clog2(ROUNDS)  t of out_word.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse after the final word (t=ROUNDS-1) is consumed.

Behaviour:
- Reset values: all outputs 0, state IDLE, round counter t=0, all 16 buffer entries cleared to 0.
- Reset mid-block: the block is abandoned and no done pulse is produced.
- States:
  - IDLE: start=1 → LOAD, t=0.
  - LOAD (t<16): the last accepted word (t=15) → EXPAND.
  - EXPAND (16≤t<ROUNDS): the last generated word (t=ROUNDS-1) → DRAIN.
  - DRAIN: out_valid && out_ready → IDLE, with done=1 in the following cycle.
- Advance condition: adv = (!out_valid || out_ready). A single output register; no skid buffer.
- LOAD:
  - in_ready = adv.
  - On in_valid && in_ready: mem[t%16] ← in_word, out_word ← in_word, out_round ← t, out_valid ← 1, t ← t+1.
- EXPAND:
  - in_ready = 0.
  - When adv: compute W from the buffer, write mem[t%16], load the output register, t ← t+1. Generates one word per cycle when the consumer never stalls.
- Latency: exactly 1 cycle from input acceptance, or from generation, to out_valid.
- With out_valid=1 and out_ready=0, out_word and out_round hold stable and nothing advances.
- Index arithmetic uses a 4-bit wrap: idx2=(t+14)&15, idx7=(t+9)&15, idx15=(t+1)&15, idx16=t&15.
- The new word overwrites slot t&15 (the W[t-16] slot) after it is read, in the same cycle.
- All additions are modulo 2^WORD_W; carries are discarded.
- Sigma functions:
  - WORD_W=32: σ0 = ROTR7⊕ROTR18⊕SHR3; σ1 = ROTR17⊕ROTR19⊕SHR10.
  - WORD_W=64: σ0 = ROTR1⊕ROTR8⊕SHR7; σ1 = ROTR19⊕ROTR61⊕SHR6.
- Boundary conditions:
  - start outside IDLE is ignored.
  - start and rst together: rst wins.
  - in_valid outside LOAD is ignored and not consumed.
  - in_ready is never high in IDLE, EXPAND or DRAIN.
  - The LOAD→EXPAND transition has no bubble: if out_ready is held high, W[16] appears the cycle after W[15].
  - A new start is accepted in the cycle done is high.

Decomposition:
- Package sha_sched_pkg holds:
  - state enum (IDLE, LOAD, EXPAND, DRAIN);
  - rotation/shift constants for both word widths;
  - the ROUNDS-vs-WORD_W legality check.
- Sub-module msg_sigma: combinational σ0/σ1, parametrised by WORD_W, instantiated twice (SEL0 and SEL1 modes).
- The top level holds the FSM, the round counter, the 16-entry buffer and the output register.

Test Plan:
- SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 → words 0..15 echoed, then W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; 64 words total, done one cycle after t=63 is consumed.
- Same block with out_ready toggled pseudo-randomly → identical word sequence; out_word/out_round stable while stalled; no word dropped or duplicated.
- in_valid gaps during LOAD (inserted every third cycle) → out_round still 0..63 contiguous; in_ready low throughout EXPAND.
- rst asserted at t=30 → next cycle all outputs 0, busy=0, no done; a fresh start then reproduces the first scenario exactly.
- WORD_W=64, ROUNDS=80 with an all-zero block → all 80 outputs 0x0, out_round reaches 79, done pulses once.
- start held high continuously → back-to-back blocks, no extra block begun mid-operation; second block accepted in the done cycle.
